// File: rtl/lms_pkg.sv
// Shared fixed-point helpers for the LMS adaptive FIR: format constants,
// generic signed saturation and a clog2 for elaboration-time sizing.
package lms_pkg;

    localparam int SAT_W = 128;
    typedef logic signed [SAT_W-1:0] wide_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int coef_frac(input int coef_width);
        return coef_width - 2;
    endfunction

    // Shift that maps a Q1.(DW-1) x Q1.(DW-1) product onto the coefficient grid.
    function automatic int upd_shift(input int data_width, input int coef_width);
        return 2 * (data_width - 1) - coef_frac(coef_width);
    endfunction

    localparam int COEF_FRAC = coef_frac(24);
    localparam int UPD_SHIFT = upd_shift(16, 24);

    function automatic wide_t sat_max(input int unsigned width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int unsigned width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic logic sat_hit(input wide_t v, input int unsigned width);
        return (v > sat_max(width)) || (v < sat_min(width));
    endfunction

    function automatic wide_t saturate(input wide_t v, input int unsigned width);
        if (v > sat_max(width)) return sat_max(width);
        if (v < sat_min(width)) return sat_min(width);
        return v;
    endfunction

endpackage

// File: rtl/lms_adaptive_fir_if.sv
// Sample stream into the filter and result stream out of it.
interface lms_adaptive_fir_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic signed [DATA_WIDTH-1:0] d_in;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] y_out;
    logic signed [DATA_WIDTH-1:0] err_out;

    modport master (
        output in_valid, x_in, d_in,
        input  out_valid, y_out, err_out
    );

    modport slave (
        input  in_valid, x_in, d_in,
        output out_valid, y_out, err_out
    );
endinterface

// File: rtl/lms_tap.sv
// One LMS tap: coefficient register with clear/write/update priority,
// saturating weight update and the w*x product for the output sum.
module lms_tap
    import lms_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 24,
    parameter int MU_W       = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic signed [DATA_WIDTH-1:0]         x_i,
    input  logic signed [DATA_WIDTH-1:0]         e_i,
    input  logic                                 upd_en_i,
    input  logic                                 clear_i,
    input  logic                                 wr_en_i,
    input  logic signed [COEF_WIDTH-1:0]         wr_data_i,
    input  logic [MU_W-1:0]                      mu_shift_i,
    output logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod_o,
    output logic                                 sat_o
);
    localparam int UPD_SH = upd_shift(DATA_WIDTH, COEF_WIDTH);
    localparam int PW     = DATA_WIDTH + COEF_WIDTH;

    typedef logic signed [PW-1:0]           prod_t;
    typedef logic signed [2*DATA_WIDTH-1:0] ex_t;

    logic signed [COEF_WIDTH-1:0] w_q, w_d;
    ex_t                          ex;
    int unsigned                  sh;
    wide_t                        sum;
    logic                         upd_hit;

    assign prod_o = prod_t'(w_q) * prod_t'(x_i);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        ex      = ex_t'(e_i) * ex_t'(x_i);
        sh      = 32'(mu_shift_i) + 32'(UPD_SH);
        sum     = wide_t'(w_q) + (wide_t'(ex) >>> sh);
        upd_hit = sat_hit(sum, COEF_WIDTH);
        w_d     = w_q;
        sat_o   = 1'b0;
        if (clear_i) begin
            w_d = '0;
        end else if (wr_en_i) begin
            w_d = wr_data_i;
        end else if (upd_en_i) begin
            w_d   = COEF_WIDTH'(saturate(sum, COEF_WIDTH));
            sat_o = upd_hit;
        end
    end

    // NOTE: state registers use non-blocking assignments so all taps see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) w_q <= '0;
        else       w_q <= w_d;
    end

endmodule

// File: rtl/lms_adaptive_fir.sv
// Streaming LMS adaptive FIR: delay line, output sum, saturated y/err
// registers and sticky saturation flag; per-tap weights live in lms_tap.
module lms_adaptive_fir
    import lms_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 24,
    parameter int TAPS       = 8,
    parameter int MU_W       = 5,
    parameter int ADDR_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    lms_adaptive_fir_if.slave            stream,
    input  logic [MU_W-1:0]              mu_shift,
    input  logic                         adapt_en,
    input  logic                         coef_clear,
    input  logic                         coef_wr_en,
    input  logic [ADDR_W-1:0]            coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    output logic                         sat_flag
);
    localparam int FRAC  = coef_frac(COEF_WIDTH);
    localparam int MAXW  = (DATA_WIDTH > COEF_WIDTH) ? DATA_WIDTH : COEF_WIDTH;
    localparam int ACC_W = 2 * MAXW + clog2(TAPS);
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [PW-1:0]         prod_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

    if (upd_shift(DATA_WIDTH, COEF_WIDTH) < 0) begin : g_bad_fmt
        $error("lms_adaptive_fir: UPD_SHIFT is negative for this DATA_WIDTH/COEF_WIDTH");
    end
    if (TAPS < 2 || (1 << ADDR_W) < TAPS) begin : g_bad_taps
        $error("lms_adaptive_fir: TAPS must be >= 2 and addressable with ADDR_W bits");
    end

    data_t           x_dl_q [TAPS];
    data_t           d_q;
    logic            pend_q;
    logic            out_valid_q;
    data_t           y_q, err_q, y_d, err_d;
    logic            sat_q, sat_d;
    prod_t           prod [TAPS];
    logic [TAPS-1:0] tap_sat;
    acc_t            acc;
    wide_t           y_wide, e_wide;
    logic            y_hit, e_hit;

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        lms_tap #(
            .DATA_WIDTH (DATA_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .MU_W       (MU_W)
        ) u_tap (
            .clk        (clk),
            .reset      (reset),
            .x_i        (x_dl_q[i]),
            .e_i        (err_d),
            .upd_en_i   (pend_q && adapt_en),
            .clear_i    (coef_clear),
            .wr_en_i    (coef_wr_en && (coef_wr_addr == ADDR_W'(i))),
            .wr_data_i  (coef_wr_data),
            .mu_shift_i (mu_shift),
            .prod_o     (prod[i]),
            .sat_o      (tap_sat[i])
        );
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + acc_t'(prod[i]);
        y_wide = wide_t'(acc >>> FRAC);
        y_hit  = sat_hit(y_wide, DATA_WIDTH);
        y_d    = data_t'(saturate(y_wide, DATA_WIDTH));
        e_wide = wide_t'(d_q) - wide_t'(y_d);
        e_hit  = sat_hit(e_wide, DATA_WIDTH);
        err_d  = data_t'(saturate(e_wide, DATA_WIDTH));
    end

    // y/err saturation only counts when a sample is actually being produced.
    always_comb begin
        sat_d = sat_q | (pend_q & (y_hit | e_hit)) | (|tap_sat);
        if (coef_clear) sat_d = 1'b0;
    end

    // NOTE: the delay line is reset along with the rest so no stale samples leak into y after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) x_dl_q[i] <= '0;
            d_q         <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            err_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (stream.in_valid) begin
                x_dl_q[0] <= stream.x_in;
                for (int i = 1; i < TAPS; i++) x_dl_q[i] <= x_dl_q[i-1];
                d_q <= stream.d_in;
            end
            pend_q      <= stream.in_valid;
            out_valid_q <= pend_q;
            if (pend_q) begin
                y_q   <= y_d;
                err_q <= err_d;
            end
            sat_q <= sat_d;
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.y_out     = y_q;
    assign stream.err_out   = err_q;
    assign sat_flag         = sat_q;

endmodule

// File: tb/tb_lms_adaptive_fir.sv
// Self-checking bench: directed scenarios plus random bursts, all compared
// every cycle against an arithmetic reference model of the LMS filter.
module tb_lms_adaptive_fir;

    localparam int DW        = 16;
    localparam int CW        = 24;
    localparam int TAPS      = 8;
    localparam int MU_W      = 5;
    localparam int AW        = 3;
    localparam int FRAC      = CW - 2;
    localparam int UPD_SHIFT = 2 * (DW - 1) - FRAC;

    logic clk = 1'b0;
    logic reset;
    logic [MU_W-1:0]      mu_shift;
    logic                 adapt_en;
    logic                 coef_clear;
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_wr_addr;
    logic signed [CW-1:0] coef_wr_data;
    logic                 sat_flag;

    always #5 clk = ~clk;

    lms_adaptive_fir_if #(.DATA_WIDTH(DW)) stream();

    lms_adaptive_fir #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .TAPS       (TAPS),
        .MU_W       (MU_W),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stream       (stream),
        .mu_shift     (mu_shift),
        .adapt_en     (adapt_en),
        .coef_clear   (coef_clear),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .sat_flag     (sat_flag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model state: weights, sample history, pending sample, outputs.
    longint mw [TAPS];
    longint mx [TAPS];
    longint md, my, me;
    bit     mpend, mvalid, msat;

    function automatic longint hi_of(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint clamp(input longint v, input int w);
        if (v > hi_of(w)) return hi_of(w);
        if (v < -hi_of(w) - 1) return -hi_of(w) - 1;
        return v;
    endfunction

    function automatic bit over(input longint v, input int w);
        return (v > hi_of(w)) || (v < -hi_of(w) - 1);
    endfunction

    task automatic model_step();
        longint acc, y, e, s;
        longint nw [TAPS];
        bit     hit;
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin mw[i] = 0; mx[i] = 0; end
            md = 0; my = 0; me = 0; mpend = 0; mvalid = 0; msat = 0;
            return;
        end
        hit = 0;
        y = my;
        e = me;
        if (mpend) begin
            acc = 0;
            for (int i = 0; i < TAPS; i++) acc += mw[i] * mx[i];
            hit |= over(acc >>> FRAC, DW);
            y = clamp(acc >>> FRAC, DW);
            hit |= over(md - y, DW);
            e = clamp(md - y, DW);
        end
        for (int i = 0; i < TAPS; i++) begin
            nw[i] = mw[i];
            if (coef_clear) nw[i] = 0;
            else if (coef_wr_en && int'(coef_wr_addr) == i) nw[i] = longint'(coef_wr_data);
            else if (mpend && adapt_en) begin
                s = mw[i] + ((e * mx[i]) >>> (int'(mu_shift) + UPD_SHIFT));
                hit |= over(s, CW);
                nw[i] = clamp(s, CW);
            end
        end
        msat   = coef_clear ? 1'b0 : (msat | hit);
        mvalid = mpend;
        my     = y;
        me     = e;
        for (int i = 0; i < TAPS; i++) mw[i] = nw[i];
        if (stream.in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = longint'(stream.x_in);
            md    = longint'(stream.d_in);
        end
        mpend = stream.in_valid;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("out_valid", stream.out_valid, mvalid);
        check("sat_flag", sat_flag, msat);
        check("y_out", stream.y_out, my);
        check("err_out", stream.err_out, me);
    endtask

    task automatic sample(input longint x, input longint d);
        stream.in_valid = 1'b1;
        stream.x_in     = DW'(x);
        stream.d_in     = DW'(d);
        cycle();
        stream.in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input longint v);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(addr);
        coef_wr_data = CW'(v);
        cycle();
        coef_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_clear();
        coef_clear = 1'b1;
        cycle();
        coef_clear = 1'b0;
    endtask

    function automatic longint rnd_data();
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        reset           = 1'b1;
        stream.in_valid = 1'b0;
        stream.x_in     = '0;
        stream.d_in     = '0;
        mu_shift        = '0;
        adapt_en        = 1'b0;
        coef_clear      = 1'b0;
        coef_wr_en      = 1'b0;
        coef_wr_addr    = '0;
        coef_wr_data    = '0;

        // Reset state and zero-coefficient readback.
        do_reset();
        do_reset();
        check("rst_out_valid", stream.out_valid, 0);
        check("rst_y", stream.y_out, 0);
        check("rst_err", stream.err_out, 0);
        check("rst_sat", sat_flag, 0);
        sample(16384, 0);
        cycle();
        check("rst_readback_y", stream.y_out, 0);

        // One adaptive step from zero weights, then read w[0] back through y.
        do_reset();
        adapt_en = 1'b1;
        mu_shift = 5'd4;
        sample(16384, 8192);
        check("lat_not_yet", stream.out_valid, 0);
        cycle();
        check("adapt_valid", stream.out_valid, 1);
        check("adapt_y", stream.y_out, 0);
        check("adapt_err", stream.err_out, 8192);
        adapt_en = 1'b0;
        sample(16384, 0);
        cycle();
        check("adapt_w0_readback", stream.y_out, 128);

        // Frozen unity tap 0: outputs repeat exactly.
        do_clear();
        write_coef(0, longint'(1) <<< 22);
        for (int k = 0; k < 10; k++) begin
            sample(1000, 1500);
            if (k > 0) begin
                check("freeze_y", stream.y_out, 1000);
                check("freeze_err", stream.err_out, 500);
            end
        end
        cycle();
        check("freeze_y_last", stream.y_out, 1000);

        // Saturation of y and err, then coef_clear.
        for (int i = 0; i < TAPS; i++) write_coef(i, (longint'(1) <<< 23) - 1);
        for (int k = 0; k < TAPS; k++) sample(32767, -32768);
        cycle();
        check("sat_y", stream.y_out, 32767);
        check("sat_err", stream.err_out, -32768);
        check("sat_flag_set", sat_flag, 1);
        do_clear();
        check("sat_flag_cleared", sat_flag, 0);
        sample(32767, 0);
        cycle();
        check("clear_y", stream.y_out, 0);

        // Random back-to-back burst with adaptation, then an idle gap.
        do_reset();
        for (int i = 0; i < TAPS; i++)
            write_coef(i, longint'($urandom_range(0, 1 << 21)) - (1 << 20));
        adapt_en = 1'b1;
        mu_shift = MU_W'($urandom_range(2, 10));
        for (int k = 0; k < 20; k++) sample(rnd_data(), rnd_data());
        cycle();
        cycle();
        check("burst_drained", stream.out_valid, 0);

        // Huge mu_shift with full-scale data, mixed valid gaps.
        mu_shift = 5'd31;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) != 0) sample(rnd_data(), rnd_data());
            else cycle();
        end

        // Reset in the middle of a burst drops everything in flight.
        mu_shift = 5'd6;
        for (int k = 0; k < 4; k++) sample(rnd_data(), rnd_data());
        reset           = 1'b1;
        stream.in_valid = 1'b1;
        cycle();
        reset           = 1'b0;
        stream.in_valid = 1'b0;
        check("midrst_valid", stream.out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("midrst_no_stale", stream.out_valid, 0);
        end

        // Coefficient write overrides the adaptive update for one tap only.
        for (int i = 0; i < TAPS; i++)
            write_coef(i, longint'($urandom_range(0, 1 << 21)) - (1 << 20));
        adapt_en = 1'b1;
        mu_shift = 5'd3;
        sample(rnd_data(), rnd_data());
        sample(rnd_data(), rnd_data());
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(2);
        coef_wr_data = CW'(12345);
        cycle();
        coef_wr_en   = 1'b0;
        adapt_en     = 1'b0;
        for (int k = 0; k < 3; k++) sample(rnd_data(), rnd_data());
        cycle();
        for (int i = 0; i < TAPS; i++) if (i != 2) write_coef(i, 0);
        sample(16384, 0);
        sample(0, 0);
        sample(0, 0);
        cycle();
        check("wr_override_w2", stream.y_out, 48);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lms_adaptive_fir.md
Name: lms_adaptive_fir

Overview:
- Parametrised, streaming LMS adaptive FIR. Next generation of the team's LMS filter.
- Adds valid handshake, runtime step size (mu as a shift), adaptation freeze, coefficient clear/load port, saturating fixed-point arithmetic and a saturation status flag.
- Sits between sample source (x_in, desired d_in) and downstream consumer of y_out/err_out.

Parameters:
- DATA_WIDTH, 16, width of x_in, d_in, y_out, err_out (signed Q1.(DATA_WIDTH-1)).
- COEF_WIDTH, 24, width of each coefficient (signed Q2.(COEF_WIDTH-2)).
- TAPS, 8, number of filter taps (>=2).
- MU_W, 5, width of mu_shift input.
- ADDR_W, 3, coefficient address width; must satisfy 2^ADDR_W >= TAPS.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  x_in/d_in valid this cycle; no backpressure, one sample per cycle max.
- x_in  in  DATA_WIDTH  reference input sample, signed.
- d_in  in  DATA_WIDTH  desired sample, signed.
- mu_shift  in  MU_W  step size; mu = 2^-mu_shift, sampled when update occurs.
- adapt_en  in  1  1 = coefficients adapt, 0 = frozen.
- coef_clear  in  1  zero all coefficients and clear sat_flag.
- coef_wr_en  in  1  load one coefficient.
- coef_wr_addr  in  ADDR_W  tap index to load; writes to an address >= TAPS are ignored.
- coef_wr_data  in  COEF_WIDTH  coefficient value.
- out_valid  out  1  y_out/err_out valid.
- y_out  out  DATA_WIDTH  filter output, saturated.
- err_out  out  DATA_WIDTH  d - y, saturated.
- sat_flag  out  1  sticky: any y, err or coefficient saturation since last reset/coef_clear.

Behaviour:
- Reset (synchronous, active-high): delay line, d register, coefficients, pending flag, out_valid, y_out, err_out and sat_flag all go to 0. Any in-flight sample is dropped.
- Stage 1, on an edge with in_valid=1:
  - x_dl[0] <= x_in, x_dl[i] <= x_dl[i-1].
  - d_reg <= d_in.
  - pend <= 1; otherwise pend <= 0.
- Stage 2, on an edge with pend=1:
  - acc = sum over i of w[i]*x_dl[i], full precision, accumulator width 2*max(DATA_WIDTH,COEF_WIDTH)+clog2(TAPS).
  - y = sat_DW(acc >>> COEF_FRAC).
  - e = sat_DW(d_reg - y).
  - y_out <= y, err_out <= e, out_valid <= 1.
  - With pend=0: out_valid <= 0, y_out and err_out hold.
- Latency: in_valid at edge N produces out_valid high after edge N+1 (2-cycle latency). Full throughput on back-to-back samples.
- Weight update, same edge as stage 2, when adapt_en=1:
  - w[i] <= sat_CW(w[i] + ((e*x_dl[i]) >>> (mu_shift + UPD_SHIFT))).
  - Uses the pre-edge x_dl and w, i.e. the same x_dl and w that produced y.
  - A simultaneous new in_valid shift does not affect this update.
- Shifts are arithmetic (floor).
- Fixed-point constants: COEF_FRAC = COEF_WIDTH-2; UPD_SHIFT = 2*(DATA_WIDTH-1) - COEF_FRAC. Elaboration error if UPD_SHIFT < 0.
- Coefficient priority per edge: reset > coef_clear > coef_wr_en (addressed tap only) > adaptive update.
  - A coefficient write overrides the adaptive update for that tap only; other taps still adapt.
- coef_clear during pending output: the output uses pre-clear coefficients; no adaptive update that edge; coefficients are 0 after the edge.
- sat_flag <= 1 on any saturation event in y, e or any coefficient. Cleared only by reset or coef_clear; reset and coef_clear take precedence over a simultaneous saturation.
- Saturation bounds: DATA_WIDTH clamps to [-2^(DW-1), 2^(DW-1)-1]; COEF_WIDTH clamps to [-2^(CW-1), 2^(CW-1)-1].
- mu_shift is large enough to zero the update: coefficients unchanged, no error.

Decomposition:
- Package lms_pkg holds:
  - localparams COEF_FRAC and UPD_SHIFT, expressed as functions of DATA_WIDTH/COEF_WIDTH.
  - Generic signed saturate function (value, target width).
  - clog2 helper.
- Sub-module lms_tap, one instance per tap:
  - Holds one coefficient register.
  - Implements clear/write/update priority and coefficient saturation.
  - Outputs w*x product and a coefficient saturation strobe.
  - Top level holds the delay line, adder tree, output registers and sat_flag.

Test Plan:
- Reset -> out_valid=0, y_out=0, err_out=0, sat_flag=0. Coefficient readback via outputs: x=16384 sample gives y=0.
- Coefs 0, adapt_en=1, mu_shift=4; one sample x=16384, d=8192 -> 2 cycles later out_valid=1, y=0, err=8192. w[0] becomes 32768 (8192*16384 >>> 12); other taps 0.
- Load w[0]=2^22 (1.0) via write port, adapt_en=0; x=1000, d=1500 -> y=1000, err=500. Repeat 10 samples: weights unchanged, outputs identical.
- Load all 8 taps with 2^23-1, feed 8 samples x=32767, then d=-32768 -> y=32767, err=-32768, sat_flag=1. coef_clear -> sat_flag=0, next y=0.
- Back-to-back in_valid for 20 cycles with random x/d -> out_valid is a 20-cycle burst delayed 2 cycles, matching a bit-exact reference model. Reset asserted mid-burst -> out_valid=0 on the next edge, no stale output afterwards.
- Simultaneous coef_wr_en (addr 2, data 12345) and adaptive update -> w[2]=12345 exactly; other taps adapted per model.
